nco_phase_fold: RTL and testbench

// - Phase-accumulator NCO front end. Drives the address port of the 1024-entry

---
 rtl/nco_phase_fold.sv | 124 ++++++++++++
 tb/tb_nco_phase_fold.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/nco_phase_fold.sv
// Phase-accumulator NCO front end: folds the full-circle phase into a quarter-wave table index and negate flag.
// Optional phase dither is enabled by defining NCO_PHASE_DITHER_EN.
module nco_phase_fold #(
    parameter int ACC_WIDTH   = 32,
    parameter int ANGLE_WIDTH = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ACC_WIDTH-1:0]   freq_in,
    input  logic                   freq_wr,
    input  logic [ACC_WIDTH-1:0]   phase_offset,
    input  logic                   phase_clr,
    output logic [ANGLE_WIDTH-1:0] angle,
    output logic                   negate,
    output logic                   out_valid,
    input  logic                   out_ready
);

    localparam int PW       = ANGLE_WIDTH + 2;
    localparam int SHIFT    = ACC_WIDTH - PW;
    localparam int DITH_RAW = ACC_WIDTH - 2 - ANGLE_WIDTH;
    localparam int DITH_W   = (DITH_RAW < 16) ? DITH_RAW : 16;

    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [ACC_WIDTH-1:0]   freq_q, freq_d;
    logic [PW-1:0]          p_q, p_d;
    logic                   s1_valid_q, s1_valid_d;
    logic [ANGLE_WIDTH-1:0] angle_q, angle_d;
    logic                   negate_q, negate_d;
    logic                   out_valid_q, out_valid_d;

    logic                   adv;
    logic [ACC_WIDTH-1:0]   dith;
    logic [ACC_WIDTH-1:0]   p_sum;
    logic [PW-1:0]          p_next;
    logic [1:0]             quad;
    logic [ANGLE_WIDTH-1:0] idx;

    assign adv = !out_valid_q || out_ready;

`ifdef NCO_PHASE_DITHER_EN
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] DITH_MASK = 16'((32'd1 << DITH_W) - 32'd1);

    logic [15:0] lfsr_q, lfsr_d;

    // Galois LFSR (x^16+x^14+x^13+x^11+1), right-shifting form
    always_comb begin
        lfsr_d = lfsr_q;
        if (phase_clr) begin
            lfsr_d = LFSR_SEED;
        end else if (adv) begin
            lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign dith = ACC_WIDTH'(lfsr_q & DITH_MASK);
`else
    assign dith = '0;
`endif

    // Only the quadrant and index bits of the offset phase are kept; the rest is truncated
    assign p_sum  = acc_q + phase_offset + dith;
    assign p_next = PW'(p_sum >> SHIFT);
    assign quad   = p_q[PW-1 -: 2];
    assign idx    = p_q[ANGLE_WIDTH-1:0];

    always_comb begin
        freq_d      = freq_wr ? freq_in : freq_q;
        acc_d       = acc_q;
        p_d         = p_q;
        s1_valid_d  = s1_valid_q;
        angle_d     = angle_q;
        negate_d    = negate_q;
        out_valid_d = out_valid_q;
        if (phase_clr) begin
            acc_d       = '0;
            s1_valid_d  = 1'b0;
            out_valid_d = 1'b0;
        end else if (adv) begin
            acc_d       = acc_q + freq_q;
            p_d         = p_next;
            s1_valid_d  = 1'b1;
            out_valid_d = s1_valid_q;
            // Odd quadrants mirror by bitwise inversion; the table is sampled at (i+0.5)
            angle_d     = quad[0] ? ~idx : idx;
            negate_d    = quad[1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            freq_q      <= '0;
            p_q         <= '0;
            s1_valid_q  <= 1'b0;
            angle_q     <= '0;
            negate_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            freq_q      <= freq_d;
            p_q         <= p_d;
            s1_valid_q  <= s1_valid_d;
            angle_q     <= angle_d;
            negate_q    <= negate_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign angle     = angle_q;
    assign negate    = negate_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_nco_phase_fold.sv
// Scoreboard bench for nco_phase_fold: stimulus pushes expected {angle,negate}, a negedge monitor pops and compares.
module tb_nco_phase_fold;

    logic        clk;
    logic        rst;
    logic [31:0] freq_in;
    logic        freq_wr;
    logic [31:0] phase_offset;
    logic        phase_clr;
    logic [9:0]  angle;
    logic        negate;
    logic        out_valid;
    logic        out_ready;

    logic [10:0] expQ[$];
    int          errors = 0;
    int          checks = 0;

    nco_phase_fold #(.ACC_WIDTH(32), .ANGLE_WIDTH(10)) dut (
        .clk          (clk),
        .rst          (rst),
        .freq_in      (freq_in),
        .freq_wr      (freq_wr),
        .phase_offset (phase_offset),
        .phase_clr    (phase_clr),
        .angle        (angle),
        .negate       (negate),
        .out_valid    (out_valid),
        .out_ready    (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Quarter-wave sweep: up, down, up negated, down negated
    function automatic logic [10:0] sweepExp(input int k);
        int quadrant;
        int pos;
        logic [9:0] a;
        quadrant = (k % 4096) / 1024;
        pos      = k % 1024;
        a        = (quadrant % 2 == 1) ? 10'(1023 - pos) : 10'(pos);
        return {a, (quadrant >= 2)};
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pushExp(input logic [9:0] a, input logic n);
        expQ.push_back({a, n});
    endtask

    // Load frequency/offset and clear the pipeline while the output is stalled
    task automatic restart(input logic [31:0] f, input logic [31:0] off);
        tick();
        freq_in      = f;
        phase_offset = off;
        freq_wr      = 1'b1;
        phase_clr    = 1'b1;
        tick();
        freq_wr   = 1'b0;
        phase_clr = 1'b0;
        checkVal("clr_valid_cycle0", {31'b0, out_valid}, 32'd0);
    endtask

    // Drain the scoreboard, optionally stalling once at a given angle
    task automatic run(input int budget, input int stallAt);
        bit stalled;
        bit done;
        stalled   = 1'b0;
        done      = 1'b0;
        out_ready = 1'b1;
        tick();
        checkVal("clr_valid_cycle1", {31'b0, out_valid}, 32'd0);
        for (int c = 0; c < budget; c++) begin
            tick();
            if (stallAt >= 0 && !stalled && out_valid && angle == 10'(stallAt)) begin
                out_ready = 1'b0;
                repeat (5) tick();
                out_ready = 1'b1;
                stalled   = 1'b1;
            end
            if (expQ.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        out_ready = 1'b0;
        if (!done) begin
            errors++;
            checks++;
            $display("[TB] FAIL drain_timeout: got %0d samples left expected 0", expQ.size());
            expQ.delete();
        end
        if (stallAt >= 0) begin
            checkVal("stall_seen", {31'b0, stalled}, 32'd1);
        end
    endtask

    // Monitor: compare accepted samples, and held samples against the pending head
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (out_ready) begin
                if (expQ.size() == 0) begin
                    errors++;
                    checks++;
                    $display("[TB] FAIL unexpected_sample: got %0h expected none", {angle, negate});
                end else begin
                    checkVal("sample", {21'b0, angle, negate}, {21'b0, expQ.pop_front()});
                end
            end else if (expQ.size() != 0) begin
                checkVal("stall_hold", {21'b0, angle, negate}, {21'b0, expQ[0]});
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst          = 1'b1;
        freq_in      = '0;
        freq_wr      = 1'b0;
        phase_offset = '0;
        phase_clr    = 1'b0;
        out_ready    = 1'b0;
        #3;
        checkVal("reset_angle", {22'b0, angle}, 32'd0);
        checkVal("reset_negate", {31'b0, negate}, 32'd0);
        checkVal("reset_valid", {31'b0, out_valid}, 32'd0);
        #19;
        rst = 1'b0;

        restart(32'h0010_0000, 32'h0);
        for (int k = 0; k <= 4096; k++) expQ.push_back(sweepExp(k));
        run(6000, 37);

        restart(32'h0, 32'h8000_0000);
        for (int k = 0; k < 8; k++) pushExp(10'd0, 1'b1);
        run(100, -1);

        restart(32'hFFF0_0000, 32'h0);
        pushExp(10'd0, 1'b0);
        pushExp(10'd0, 1'b1);
        pushExp(10'd1, 1'b1);
        pushExp(10'd2, 1'b1);
        run(100, -1);

        restart(32'h4000_0000, 32'h0050_0000);
        pushExp(10'd5, 1'b0);
        pushExp(10'd1018, 1'b0);
        pushExp(10'd5, 1'b1);
        pushExp(10'd1018, 1'b1);
        pushExp(10'd5, 1'b0);
        run(100, -1);

        checkVal("stalled_before_rst", {21'b0, angle, out_valid}, {21'b0, 10'd1018, 1'b1});
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkVal("async_rst_angle", {22'b0, angle}, 32'd0);
        checkVal("async_rst_negate", {31'b0, negate}, 32'd0);
        checkVal("async_rst_valid", {31'b0, out_valid}, 32'd0);
        #20;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
